ckt_delay_line: RTL and testbench

Parametrised, clocked, per-bit delay line with selectable min/typ/max/custom delay. It is the synthesizable successor to our gate-level min:typ:max delay models: it delays a WIDTH-bit sample stream by a runtime-selected number of clock cycles. It flushes cleanly on any delay change and reports when the output is settled. It sits between stimulus and checker logic, or in datapaths that need cycle-exact skew alignment.

---
 rtl/ckt_delay_line.sv | 107 ++++++++++
 tb/tb_ckt_delay_line.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ckt_delay_line.sv
// Clocked per-bit delay line with min/typ/max/custom delay selection.
// Flushes on any delay change and flags the refill period via settling.
module ckt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16,
  parameter int DMIN  = 1,
  parameter int DTYP  = 2,
  parameter int DMAX  = 3,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    cust_dly,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             settling,
  output logic [DW-1:0]    cur_dly
);

  typedef enum logic {
    RUN,
    SETTLE
  } state_t;

  function automatic logic [DW-1:0] clampd(input int v);
    if (v < 1)     return DW'(1);
    if (v > DEPTH) return DW'(DEPTH);
    return DW'(v);
  endfunction

  state_t           state;
  logic [DEPTH-1:0] sv;
  logic [WIDTH-1:0] sd [DEPTH];
  logic [DW-1:0]    cnt;
  logic [DW-1:0]    eff;
  int               sel;
  logic             chg;
  logic             tap_v;
  logic [WIDTH-1:0] tap_d;

  always_comb begin
    sel = 0;
    unique case (mode)
      2'b00: sel = DMIN;
      2'b01: sel = DTYP;
      2'b10: sel = DMAX;
      2'b11: sel = int'(cust_dly);
    endcase
    eff = clampd(sel);
  end

  assign chg = (eff != cur_dly);

  always_comb begin
    tap_v = 1'b0;
    tap_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (cur_dly == DW'(k + 1)) begin
        tap_v = sv[k];
        tap_d = sd[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv       <= '0;
      for (int k = 0; k < DEPTH; k++) sd[k] <= '0;
      state    <= RUN;
      cur_dly  <= clampd(DMIN);
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      settling <= 1'b0;
    end else begin
      sd[0] <= din;
      for (int k = 1; k < DEPTH; k++) sd[k] <= sd[k-1];
      if (chg) begin
        // drop everything in flight but keep this cycle's sample
        sv       <= {{(DEPTH-1){1'b0}}, din_vld};
        cur_dly  <= eff;
        cnt      <= eff;
        state    <= SETTLE;
        settling <= 1'b1;
        dout_vld <= 1'b0;
        dout     <= '0;
      end else begin
        sv <= {sv[DEPTH-2:0], din_vld};
        if (state == SETTLE && cnt != DW'(1)) begin
          cnt      <= cnt - DW'(1);
          settling <= 1'b1;
          dout_vld <= 1'b0;
          dout     <= '0;
        end else begin
          state    <= RUN;
          settling <= 1'b0;
          dout_vld <= tap_v;
          dout     <= tap_v ? tap_d : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ckt_delay_line.sv
// Bench for ckt_delay_line: timestamped reference model plus
// directed scenarios and randomized traffic.
module tb_ckt_delay_line;
  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int HMAX  = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [DW-1:0]    cust_dly;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             settling;
  logic [DW-1:0]    cur_dly;

  ckt_delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .DMIN (1),
    .DTYP (2),
    .DMAX (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .cust_dly(cust_dly),
    .din     (din),
    .din_vld (din_vld),
    .dout    (dout),
    .dout_vld(dout_vld),
    .settling(settling),
    .cur_dly (cur_dly)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampd(input int v);
    if (v < 1) return 1;
    if (v > DEPTH) return DEPTH;
    return v;
  endfunction

  function automatic int pick(input logic [1:0] m, input int c);
    case (m)
      2'b00:   return clampd(1);
      2'b01:   return clampd(2);
      2'b10:   return clampd(3);
      default: return clampd(c);
    endcase
  endfunction

  // Reference model: every edge gets an index; a sample taken at edge s
  // appears after edge s+dly if s is at/after the last flush point.
  logic             hv [HMAX];
  logic [WIDTH-1:0] hd [HMAX];
  int cyc      = 0;
  int m_dly    = 1;
  int chg_edge = -1000;
  int flush_at = 0;

  always @(posedge clk) begin
    int e_set, e_v, e_d, src, eff;
    if (rst) begin
      m_dly    = clampd(1);
      chg_edge = -1000;
      flush_at = cyc + 1;
      e_set = 0; e_v = 0; e_d = 0;
    end else begin
      eff = pick(mode, int'(cust_dly));
      if (eff != m_dly) begin
        m_dly    = eff;
        chg_edge = cyc;
        flush_at = cyc;
      end
      hv[cyc % HMAX] = din_vld;
      hd[cyc % HMAX] = din;
      e_set = (cyc < chg_edge + m_dly) ? 1 : 0;
      src   = cyc - m_dly;
      e_v   = (e_set == 0 && src >= flush_at && hv[src % HMAX]) ? 1 : 0;
      e_d   = e_v ? int'(hd[src % HMAX]) : 0;
    end
    #1;
    check("m_dout_vld", int'(dout_vld), e_v);
    check("m_dout", int'(dout), e_d);
    check("m_settling", int'(settling), e_set);
    check("m_cur_dly", int'(cur_dly), m_dly);
    cyc++;
  end

  task automatic count_settle(input string nm, input int exp);
    int n;
    n = 0;
    @(posedge clk); #2;
    while (settling && n < 40) begin
      n++;
      if (dout_vld) check({nm, "_vld_in_settle"}, 1, 0);
      @(posedge clk); #2;
    end
    check(nm, n, exp);
  endtask

  initial begin
    int lat;
    rst = 1'b1; mode = 2'b00; cust_dly = '0; din = '0; din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dout_vld", int'(dout_vld), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_settling", int'(settling), 0);
    check("rst_cur_dly", int'(cur_dly), 1);

    @(negedge clk); rst = 1'b0; din = 4'h1; din_vld = 1'b1;
    @(negedge clk); din = '0; din_vld = 1'b0;
    @(posedge clk); #2;
    check("dmin_vld", int'(dout_vld), 1);
    check("dmin_dout", int'(dout), 1);
    @(posedge clk); #2;
    check("dmin_one_cycle", int'(dout_vld), 0);

    @(negedge clk); mode = 2'b10;
    count_settle("settle_dmax", 3);
    check("cur_dmax", int'(cur_dly), 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_vld = (i != 2);
      din = WIDTH'((i == 0 || i == 3 || i == 4) ? 1 : 0);
    end
    @(negedge clk); din_vld = 1'b0;
    repeat (5) @(negedge clk);

    mode = 2'b11; cust_dly = '0;
    count_settle("settle_c0", 1);
    check("cur_c0", int'(cur_dly), 1);
    @(negedge clk); cust_dly = DW'(20);
    count_settle("settle_c20", 16);
    check("cur_c20", int'(cur_dly), 16);
    @(negedge clk); din_vld = 1'b1; din = 4'h5;
    @(posedge clk);
    @(negedge clk); din_vld = 1'b0; din = '0;
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!dout_vld && lat < 40);
    check("lat_c20", lat, 16);
    check("lat_c20_dout", int'(dout), 5);

    @(negedge clk); mode = 2'b01;
    count_settle("settle_typ", 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); din_vld = 1'b1; din = WIDTH'(i + 3);
    end
    @(negedge clk); mode = 2'b11; cust_dly = DW'(5); din = 4'hA;
    count_settle("settle_c5", 5);
    repeat (8) begin
      @(negedge clk); din = WIDTH'($urandom);
    end

    @(negedge clk); cust_dly = DW'(7);
    count_settle("settle_c7", 7);
    @(negedge clk); cust_dly = DW'(5);
    @(posedge clk);
    @(posedge clk); #2;
    check("restart_pre", int'(settling), 1);
    @(negedge clk); cust_dly = DW'(3);
    count_settle("settle_restart", 3);

    @(negedge clk); cust_dly = DW'(10); din = 4'h9;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_vld", int'(dout_vld), 0);
    check("rst_mid_dout", int'(dout), 0);
    check("rst_mid_settling", int'(settling), 0);
    check("rst_mid_cur", int'(cur_dly), 1);
    @(negedge clk); rst = 1'b0; mode = 2'b00; din_vld = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) begin
        mode     = 2'($urandom);
        cust_dly = DW'($urandom_range(20));
      end
      din_vld = 1'($urandom);
      din     = WIDTH'($urandom);
    end
    @(negedge clk); rst = 1'b0; din_vld = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
